// File: rtl/pdm_decoder.sv
// PDM microphone front end: drives mic_clk, synchronises the PDM bit and decimates
// by counting ones per window. Optional PDM_DEC_SMOOTH_EN adds a two-tap average.
module pdm_decoder #(
  parameter int NBITS      = 10,
  parameter int CLK_HALF   = 21,
  parameter int DECIM_LOG2 = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pdm_data,
  output logic             mic_clk,
  output logic             mic_lrsel,
  output logic [NBITS-1:0] dout,
  output logic             dout_valid
);

  localparam int DECIM = 1 << DECIM_LOG2;
  localparam int DIV_W = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam int CNT_W = DECIM_LOG2 + 1;
  localparam int SHIFT = NBITS - DECIM_LOG2;

  logic [DIV_W-1:0]      div_cnt;
  logic                  div_wrap;
  logic                  pdm_m;
  logic                  pdm_s;
  logic [DECIM_LOG2-1:0] bit_cnt;
  logic [CNT_W-1:0]      ones;
  logic                  sample;
  logic                  last_bit;
  logic [CNT_W-1:0]      cnt_p0;
  logic                  vld_p0;
  logic [NBITS-1:0]      pcm_p0;

  // A full window (cnt == DECIM) would overflow the shift, so it saturates.
  function automatic logic [NBITS-1:0] sat_scale(input logic [CNT_W-1:0] c);
    if (c[DECIM_LOG2])
      return {NBITS{1'b1}};
    else
      return NBITS'(c[DECIM_LOG2-1:0]) << SHIFT;
  endfunction

`ifdef PDM_DEC_SMOOTH_EN
  function automatic logic [NBITS-1:0] smooth_avg(input logic [NBITS-1:0] a,
                                                  input logic [NBITS-1:0] b);
    logic [NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[NBITS:1];
  endfunction
`endif

  assign mic_lrsel = 1'b0;
  assign div_wrap  = (div_cnt == DIV_W'(CLK_HALF - 1));
  assign sample    = en & mic_clk & div_wrap;
  assign last_bit  = sample & (&bit_cnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pdm_m <= 1'b0;
      pdm_s <= 1'b0;
    end else begin
      pdm_m <= pdm_data;
      pdm_s <= pdm_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      div_cnt <= '0;
      mic_clk <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      mic_clk <= ~mic_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Windows are back to back: the last bit's edge also restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      bit_cnt <= '0;
      ones    <= '0;
    end else if (sample) begin
      if (&bit_cnt) begin
        bit_cnt <= '0;
        ones    <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
        ones    <= ones + CNT_W'(pdm_s);
      end
    end
  end

  // Stage p0: latch the completed window count
  always_ff @(posedge clk) begin
    if (last_bit)
      cnt_p0 <= ones + CNT_W'(pdm_s);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      vld_p0 <= 1'b0;
    else
      vld_p0 <= last_bit;
  end

  assign pcm_p0 = sat_scale(cnt_p0);

  // Stage p1: scaled (optionally averaged) sample onto the output
`ifdef PDM_DEC_SMOOTH_EN
  logic [NBITS-1:0] prev_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      prev_p1    <= '0;
    end else begin
      dout_valid <= vld_p0;
      if (vld_p0) begin
        dout    <= smooth_avg(prev_p1, pcm_p0);
        prev_p1 <= pcm_p0;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= vld_p0;
      if (vld_p0)
        dout <= pcm_p0;
    end
  end
`endif

endmodule

// File: tb/tb_pdm_decoder.sv
// Directed bench for pdm_decoder: reset, constant/alternating/63-of-64 windows,
// window spacing and the en drop/re-raise sequence. Honours PDM_DEC_SMOOTH_EN.
module tb_pdm_decoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       pdm_data;
  logic       mic_clk;
  logic       mic_lrsel;
  logic [9:0] dout;
  logic       dout_valid;

  int         n_cmp;
  int         n_err;
  int         rise_idx;
  logic       mic_prev;
  logic [63:0] pat;

`ifdef PDM_DEC_SMOOTH_EN
  localparam int EXP_W1 = 511,  EXP_W2 = 1023, EXP_W3 = 511, EXP_W4 = 0;
  localparam int EXP_W5 = 256,  EXP_W6 = 760,  EXP_W7 = 1015;
`else
  localparam int EXP_W1 = 1023, EXP_W2 = 1023, EXP_W3 = 0,   EXP_W4 = 0;
  localparam int EXP_W5 = 512,  EXP_W6 = 1008, EXP_W7 = 1023;
`endif

  pdm_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pdm_data   (pdm_data),
    .mic_clk    (mic_clk),
    .mic_lrsel  (mic_lrsel),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; a new PDM bit is presented at each mic_clk rise, indexed by the window position.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mic_clk && !mic_prev) begin
      pdm_data = pat[rise_idx & 63];
      rise_idx++;
    end
    mic_prev = mic_clk;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!dout_valid && n < 6000);
  endtask

  task automatic window(input string tag, input int exp_dout);
    int n;
    tick();
    check({tag, "_valid_width"}, dout_valid, 0);
    wait_valid(n);
    check({tag, "_spacing"}, n, 2687);
    check({tag, "_dout"}, dout, exp_dout);
  endtask

  initial begin
    int n;
    int r0;
    logic saw_valid;
    logic bad_hold;

    n_cmp    = 0;
    n_err    = 0;
    rise_idx = 0;
    mic_prev = 1'b0;
    pat      = '1;
    rst_n    = 1'b0;
    en       = 1'b1;
    pdm_data = 1'b1;

    repeat (5) tick();
    check("rst_mic_clk", mic_clk, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("lrsel", mic_lrsel, 0);

    rst_n    = 1'b1;
    rise_idx = 0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!mic_clk && n < 100);
    check("first_rise", n, 21);

    wait_valid(n);
    check("w1_latency", n, 2668);
    check("w1_dout", dout, EXP_W1);

    window("w2_ones", EXP_W2);
    pat = '0;
    window("w3_zero", EXP_W3);
    window("w4_zero", EXP_W4);
    pat = 64'h5555_5555_5555_5555;
    window("w5_alt", EXP_W5);
    pat = 64'h7FFF_FFFF_FFFF_FFFF;
    window("w6_63", EXP_W6);

    // Partial window of 30 completed bits, then en drops
    pat       = '1;
    r0        = rise_idx;
    saw_valid = 1'b0;
    n = 0;
    while (rise_idx < r0 + 31 && n < 3000) begin
      tick();
      n++;
      if (dout_valid) saw_valid = 1'b1;
    end
    check("partial_no_valid", {31'd0, saw_valid}, 0);
    en = 1'b0;
    tick();
    check("en_low_mic_clk", mic_clk, 0);
    bad_hold = 1'b0;
    repeat (100) begin
      tick();
      if (mic_clk !== 1'b0 || dout_valid !== 1'b0) bad_hold = 1'b1;
    end
    check("en_low_hold", {31'd0, bad_hold}, 0);
    check("en_low_dout_held", dout, EXP_W6);

    en       = 1'b1;
    rise_idx = 0;
    wait_valid(n);
    check("reen_latency", n, 2689);
    check("w7_dout", dout, EXP_W7);
    tick();
    check("w7_valid_width", dout_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
